vga_fb_dbuf: RTL

- Parametrised successor to the single-page 2-bit-per-channel VGA framebuffer.
- Generalised colour depth and resolution; optional double buffering with frame-synchronous page flip; hardware fill engine for clearing the back page.
- Sits on the CPU MMIO bus on the write side and feeds the VGA timing generator on the scan side, in one clock domain.
- Scan side has a fixed 1-cycle read latency.

---
 rtl/vga_fb_dbuf_if.sv | 12 +
 rtl/vga_fb_dbuf.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/vga_fb_dbuf_if.sv
// CPU MMIO bus into the framebuffer: chip select, write strobe, address,
// write data and the registered control readback.
interface vga_fb_dbuf_if;
    logic        sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] din;
    logic [31:0] dout;

    modport master (output sel, output we, output addr, output din, input dout);
    modport slave  (input sel, input we, input addr, input din, output dout);
endinterface

// File: rtl/vga_fb_dbuf.sv
// Parametrised VGA framebuffer: optional double buffering with frame-synchronous
// page flip, a back-page fill engine and a 1-cycle registered scan read path.
//
// state | meaning
// IDLE  | fill engine inactive; pixel writes reach the back page
// FILL  | fill_color written to back[fill_cnt] every cycle; pixel writes dropped
module vga_fb_dbuf #(
    parameter int H_RES      = 640,
    parameter int V_RES      = 480,
    parameter int BPC        = 2,
    parameter int DOUBLE_BUF = 1,
    parameter int CTRL_BIT   = 20
) (
    input  logic        clock,
    input  logic        reset,
    vga_fb_dbuf_if.slave bus,
    input  logic [9:0]  h_addr,
    input  logic [9:0]  v_addr,
    input  logic        de,
    input  logic        frame_start,
    output logic [11:0] vga_data,
    output logic        vga_de,
    output logic        fill_busy
);
    localparam int N     = H_RES * V_RES;
    localparam int IW    = $clog2(N);
    localparam int CW    = 3 * BPC;
    localparam int DEPTH = (DOUBLE_BUF + 1) * N;
    localparam int AW    = $clog2(DEPTH);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] FILL = 1'b1;

    logic [CW-1:0] mem [DEPTH];
    logic [0:0]    state;
    logic [IW-1:0] fill_cnt;
    logic [CW-1:0] fill_color;
    logic          front;
    logic          swap_pending;
    logic          back_pg;
    logic          scan_pg;
    logic [IW-1:0] pix_idx;
    logic          ctrl_sel;
    logic          pix_we;
    logic          ctrl_we;
    logic          ctrl_rd;
    logic          swap_req;
    logic          fill_req;
    logic          flip;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [AW-1:0] mem_raddr;
    logic [CW-1:0] mem_wdata;
    logic [CW-1:0] rd_word;
    logic [31:0]   scan_idx;
    logic          scan_ok;
    logic          unused_bits;

    function automatic logic [AW-1:0] page_addr(input logic pg, input logic [IW-1:0] idx);
        return pg ? AW'(N) + AW'(idx) : AW'(idx);
    endfunction

    // Replicate the stored channel MSB-first and keep the top 4 bits.
    function automatic logic [3:0] expand(input logic [BPC-1:0] c);
        logic [4*BPC-1:0] rep;
        rep = {4{c}};
        return rep[4*BPC-1 -: 4];
    endfunction

    assign fill_busy = (state == FILL);
    assign ctrl_sel  = bus.addr[CTRL_BIT];
    assign pix_idx   = bus.addr[IW-1:0];
    assign pix_we    = bus.sel & bus.we & ~ctrl_sel & (32'(pix_idx) < 32'(N)) & ~fill_busy;
    assign ctrl_we   = bus.sel & bus.we & ctrl_sel;
    assign ctrl_rd   = bus.sel & ~bus.we & ctrl_sel;
    assign swap_req  = ctrl_we & ~bus.addr[2] & bus.din[0] & (DOUBLE_BUF != 0);
    assign fill_req  = ctrl_we & bus.addr[2] & ~fill_busy;
    assign flip      = frame_start & swap_pending & ~fill_busy;
    assign back_pg   = (DOUBLE_BUF != 0) ? ~front : 1'b0;
    assign scan_pg   = (DOUBLE_BUF != 0) ? front : 1'b0;

    // Fill and pixel writes never coincide: pixel writes are dropped while filling.
    assign mem_we    = fill_busy | pix_we;
    assign mem_waddr = page_addr(back_pg, fill_busy ? fill_cnt : pix_idx);
    assign mem_wdata = fill_busy ? fill_color : bus.din[CW-1:0];

    assign scan_idx  = 32'(v_addr) * 32'(H_RES) + 32'(h_addr);
    assign scan_ok   = de & (scan_idx < 32'(N));
    assign mem_raddr = page_addr(scan_pg, scan_idx[IW-1:0]);
    assign rd_word   = mem[mem_raddr];

    assign unused_bits = ^{bus.addr, bus.din};

    always_ff @(posedge clock) begin
        if (mem_we)
            mem[mem_waddr] <= mem_wdata;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            fill_cnt     <= '0;
            fill_color   <= '0;
            front        <= 1'b0;
            swap_pending <= 1'b0;
            bus.dout     <= '0;
            vga_data     <= '0;
            vga_de       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (fill_req) begin
                        fill_color <= bus.din[CW-1:0];
                        fill_cnt   <= '0;
                        state      <= FILL;
                    end
                end
                FILL: begin
                    if (32'(fill_cnt) == 32'(N - 1)) begin
                        fill_cnt <= '0;
                        state    <= IDLE;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A request landing on the flip edge re-arms pending for the next frame.
            if (flip) begin
                front        <= ~front;
                swap_pending <= 1'b0;
            end
            if (swap_req)
                swap_pending <= 1'b1;

            if (ctrl_rd)
                bus.dout <= {29'b0, fill_busy, swap_pending, front};

            vga_de   <= de;
            vga_data <= scan_ok ? {expand(rd_word[3*BPC-1 -: BPC]),
                                   expand(rd_word[2*BPC-1 -: BPC]),
                                   expand(rd_word[BPC-1:0])} : 12'h000;
        end
    end
endmodule
